// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: MIPS control decode in ID, carried through ID/EX, EX/MEM and MEM/WB.
// Define CU_MULTICYCLE_EN to decode opcode 7 as a multi-cycle MUL that holds EX (Busy).
module pipelined_control_unit #(
  parameter int unsigned OPW       = 4,
  parameter int unsigned FNW       = 3,
  parameter int unsigned ALUW      = 3,
  parameter int unsigned SELW      = 9,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OPW-1:0]  OpCode,
  input  logic [FNW-1:0]  Function,
  input  logic            InstrValid,
  input  logic            Stall,
  input  logic            Flush,
  output logic [ALUW-1:0] EX_ALU,
  output logic [SELW-1:0] EX_SEL,
  output logic            EX_Valid,
  output logic            MEM_MWE,
  output logic            WB_WE,
  output logic            WB_OUTLD,
  output logic            Busy,
  output logic            IllegalOp
);

  logic            d_we, d_mwe, d_outld, d_ill;
  logic [SELW-1:0] d_sel;
  logic [ALUW-1:0] d_alu;
  logic            ex_we, ex_mwe, ex_outld;
  logic            mem_we, mem_outld;
`ifdef CU_MULTICYCLE_EN
  logic            d_mul, ex_mul;
`endif

  always_comb begin
    d_we    = 1'b0;
    d_mwe   = 1'b0;
    d_outld = 1'b0;
    d_ill   = 1'b0;
    d_sel   = '0;
    d_alu   = '0;
`ifdef CU_MULTICYCLE_EN
    d_mul   = 1'b0;
`endif
    if (InstrValid) begin
      case (OpCode)
        OPW'(0): begin d_we = 1'b1; d_sel[4:0] = 5'b00010; d_alu = ALUW'(Function); end
        OPW'(1): begin d_we = 1'b1; d_sel[4:0] = 5'b00001; end
        OPW'(2): begin d_we = 1'b1; d_sel[4:0] = 5'b00101; end
        OPW'(3): begin d_mwe = 1'b1; d_sel[4:0] = 5'b00001; end
        OPW'(4): begin d_sel[4:0] = 5'b01000; d_alu = ALUW'(1); end
        OPW'(5): d_sel[4:0] = 5'b10000;
        OPW'(6): d_outld = 1'b1;
`ifdef CU_MULTICYCLE_EN
        OPW'(7): begin
          d_we = 1'b1; d_sel[4:0] = 5'b00010; d_alu = ALUW'(7); d_mul = 1'b1;
        end
`endif
        default: d_ill = 1'b1;
      endcase
    end
  end

  // ID/EX: hold while Busy, bubble on Flush/Stall, otherwise take the decode
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      EX_Valid  <= 1'b0;
      IllegalOp <= 1'b0;
      EX_ALU    <= '0;
      EX_SEL    <= '0;
      ex_we     <= 1'b0;
      ex_mwe    <= 1'b0;
      ex_outld  <= 1'b0;
    end else if (!Busy) begin
      if (Flush || Stall) begin
        EX_Valid  <= 1'b0;
        IllegalOp <= 1'b0;
        EX_ALU    <= '0;
        EX_SEL    <= '0;
        ex_we     <= 1'b0;
        ex_mwe    <= 1'b0;
        ex_outld  <= 1'b0;
      end else begin
        EX_Valid  <= InstrValid;
        IllegalOp <= d_ill;
        EX_ALU    <= d_alu;
        EX_SEL    <= d_sel;
        ex_we     <= d_we;
        ex_mwe    <= d_mwe;
        ex_outld  <= d_outld;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MEM_MWE   <= 1'b0;
      mem_we    <= 1'b0;
      mem_outld <= 1'b0;
      WB_WE     <= 1'b0;
      WB_OUTLD  <= 1'b0;
    end else begin
      MEM_MWE   <= ex_mwe && !Busy;
      mem_we    <= ex_we && !Busy;
      mem_outld <= ex_outld && !Busy;
      WB_WE     <= mem_we;
      WB_OUTLD  <= mem_outld;
    end
  end

`ifdef CU_MULTICYCLE_EN
  typedef enum logic {IDLE, RUN} state_t;
  localparam int unsigned CW = (MC_CYCLES > 2) ? $clog2(MC_CYCLES) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ex_mul <= 1'b0;
    else if (!Busy) ex_mul <= d_mul && !(Flush || Stall);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Busy covers the entry cycle plus MC_CYCLES-1 counted cycles; the MUL leaves EX in the cycle cnt hits 0
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    Busy     = 1'b0;
    case (state)
      IDLE: if (ex_mul) begin
        Busy     = 1'b1;
        state_nx = RUN;
        cnt_nx   = CW'(MC_CYCLES - 1);
      end
      RUN: if (cnt == '0) begin
        state_nx = IDLE;
      end else begin
        Busy   = 1'b1;
        cnt_nx = cnt - CW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end
`else
  assign Busy = 1'b0;
`endif

endmodule
